porta_logica_acc: RTL and testbench

//  Parametrised N-input, W-bit registered logic gate: second-generation porta block.

---
 rtl/porta_logica_acc.sv | 95 +++++++++
 tb/tb_porta_logica_acc.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/porta_logica_acc.sv
// porta_logica_acc: N-lane registered bitwise gate (AND/OR/XOR/NAND) with per-beat or accumulate mode.
module porta_logica_acc #(
    parameter int N_IN    = 3,
    parameter int WIDTH   = 8,
    parameter int ACC_LEN = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_IN*WIDTH-1:0]          in_data,
    input  logic [1:0]                     op,
    input  logic                           sel,
    input  logic                           mode,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic                           out_last,
    output logic [$clog2(ACC_LEN+1)-1:0]   beat_cnt
);
    localparam int CW = $clog2(ACC_LEN+1);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t state;
    logic [1:0] op_l, eff_op;
    logic [WIDTH-1:0] acc, r_and, r_or, r_xor, base, beat_r, acc_next;
    logic accept;
    always_comb begin
        r_and = '1;
        r_or = '0;
        r_xor = '0;
        for (int k = 0; k < N_IN; k++) begin
            r_and = r_and & in_data[k*WIDTH +: WIDTH];
            r_or = r_or | in_data[k*WIDTH +: WIDTH];
            r_xor = r_xor ^ in_data[k*WIDTH +: WIDTH];
        end
    end
    // Once accumulating, the op latched at the first beat governs every later beat
    assign eff_op = state == ACCUM ? op_l : op;
    assign base = !sel ? '0 : eff_op == 2'b01 ? r_or : eff_op == 2'b10 ? r_xor : r_and;
    assign beat_r = (sel && eff_op == 2'b11) ? ~base : base;
    assign acc_next = op_l == 2'b01 ? acc | base : op_l == 2'b10 ? acc ^ base : acc & base;
    assign in_ready = state == IDLE ? (!out_valid || out_ready) : state == ACCUM;
    assign accept = in_valid && in_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            out_valid <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
            beat_cnt <= '0;
            acc <= '0;
            op_l <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last <= 1'b0;
                    end
                    if (accept && !mode) begin
                        out_data <= beat_r;
                        out_valid <= 1'b1;
                        out_last <= 1'b1;
                    end else if (accept) begin
                        acc <= base;
                        op_l <= op;
                        beat_cnt <= CW'(1);
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        beat_cnt <= beat_cnt + CW'(1);
                        if (beat_cnt == CW'(ACC_LEN-1)) begin
                            out_data <= op_l == 2'b11 ? ~acc_next : acc_next;
                            out_valid <= 1'b1;
                            out_last <= 1'b1;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last <= 1'b0;
                        beat_cnt <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_porta_logica_acc.sv
// tb_porta_logica_acc: directed stimulus with a scoreboard of expected results popped on each output handshake.
module tb_porta_logica_acc;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, sel, mode, out_valid, out_ready, out_last;
    logic [23:0] in_data;
    logic [1:0] op;
    logic [7:0] out_data;
    logic [2:0] beat_cnt;
    logic [7:0] sb[$];
    int n_cmp = 0;
    int n_err = 0;

    porta_logica_acc #(.N_IN(3), .WIDTH(8), .ACC_LEN(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .op(op), .sel(sel), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one beat and waits (bounded) until it is accepted
    task automatic send(input logic [23:0] d, input logic [1:0] o, input logic s, input logic m);
        logic acc;
        int n;
        in_data = d;
        op = o;
        sel = s;
        mode = m;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("accept", {31'd0, acc}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) chk("out_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
            chk("out_last", {31'd0, out_last}, 32'd1);
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 24'hFFF03C;
        op = 2'b00;
        sel = 1'b1;
        mode = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'h00);
        chk("rst_beat_cnt", {29'd0, beat_cnt}, 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_no_output", {31'd0, out_valid}, 32'd0);

        sb.push_back(8'h30); send(24'hFFF03C, 2'b00, 1'b1, 1'b0);
        chk("lat_and", {31'd0, out_valid}, 32'd1);
        sb.push_back(8'hFF); send(24'hFFF03C, 2'b01, 1'b1, 1'b0);
        sb.push_back(8'h33); send(24'hFFF03C, 2'b10, 1'b1, 1'b0);
        sb.push_back(8'hCF); send(24'hFFF03C, 2'b11, 1'b1, 1'b0);
        sb.push_back(8'h00); send(24'hFFF03C, 2'b11, 1'b0, 1'b0);
        chk("lat_sel0", {31'd0, out_valid}, 32'd1);
        tick();

        out_ready = 1'b0;
        sb.push_back(8'h30); send(24'hFFF03C, 2'b00, 1'b1, 1'b0);
        sb.push_back(8'hFF);
        in_data = 24'hFFF03C;
        op = 2'b01;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_held_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_held_data", {24'd0, out_data}, 32'h30);
        end
        out_ready = 1'b1;
        send(24'hFFF03C, 2'b01, 1'b1, 1'b0);
        tick();

        sb.push_back(8'h0F);
        send(24'h000001, 2'b10, 1'b1, 1'b1); chk("xor_cnt1", {29'd0, beat_cnt}, 32'd1);
        send(24'h000002, 2'b10, 1'b1, 1'b1); chk("xor_cnt2", {29'd0, beat_cnt}, 32'd2);
        chk("xor_no_early_out", {31'd0, out_valid}, 32'd0);
        send(24'h000004, 2'b10, 1'b1, 1'b1); chk("xor_cnt3", {29'd0, beat_cnt}, 32'd3);
        send(24'h000008, 2'b10, 1'b1, 1'b1); chk("xor_cnt4", {29'd0, beat_cnt}, 32'd4);
        chk("xor_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("xor_cnt_clr", {29'd0, beat_cnt}, 32'd0);

        sb.push_back(8'h01);
        send(24'hFFFFFF, 2'b11, 1'b1, 1'b1);
        send(24'hFFFFFF, 2'b01, 1'b1, 1'b1);
        send(24'hFFFFFE, 2'b11, 1'b1, 1'b1);
        send(24'hFFFFFF, 2'b11, 1'b1, 1'b1);
        chk("nand_valid", {31'd0, out_valid}, 32'd1);
        tick();

        send(24'hFFFFFF, 2'b00, 1'b1, 1'b1);
        send(24'hFFFFFF, 2'b00, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_cnt", {29'd0, beat_cnt}, 32'd0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back(8'hFF);
        for (int i = 0; i < 4; i++) send(24'hFFFFFF, 2'b00, 1'b1, 1'b1);
        chk("and_acc_valid", {31'd0, out_valid}, 32'd1);
        repeat (3) tick();
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
